gate_array_checker: RTL
=======================

Name: gate_array_checker

Overview:
- Self-checking stimulus/response stage placed directly upstream of an instance-array gate bank: `nand #2 u_nand[WIDTH-1:0] (out1, in1, in2)`.
- Generates a pseudo-random sequence of `in1`/`in2` vectors from an LFSR and drives them to the bank.
- After each vector it waits a settle window, samples the bank's `out1` and compares it against the expected `~(in1 & in2)`.
- Reports error count, sticky mismatch bits and pass/done status.

Parameters:
- `WIDTH`, 8: gate-array instance count; bus width of `in1`/`in2`/`out1`.
- `NUM_VECTORS`, 16: vectors applied per run (≥1).
- `SETTLE_CYCLES`, 3: wait cycles between drive and sample (≥1). Must cover the gate delay.
- `SEED`, 16'hACE1: initial LFSR value (2*`WIDTH` bits). A zero seed is replaced by 1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle run request; sampled only in IDLE.
- `in1` out `WIDTH`: gate-array operand A, registered.
- `in2` out `WIDTH`: gate-array operand B, registered.
- `out1` in `WIDTH`: gate-array response.
- `busy` out 1: high from the cycle after `start` until DONE.
- `done` out 1: high in DONE, held until the next accepted `start` or `rst`.
- `pass` out 1: `err_count==0`; meaningful only while `done`.
- `err_count` out `$clog2(NUM_VECTORS+1)`: saturating count of mismatching vectors.
- `fail_bits` out `WIDTH`: mismatch bit accumulator (see Optional Feature).

Behaviour:
- Reset (synchronous on `rst` at a `clk` edge):
  - state=IDLE; `in1`=`in2`=0; `busy`=`done`=`pass`=0; `err_count`=0; `fail_bits`=0; LFSR=`SEED`; vector index=0.
  - `rst` mid-run aborts immediately, with no partial `done`.
- LFSR: 2*`WIDTH`-bit Galois, shifting right, with the tap mask from the shared header (16-bit mask = 16'hB400). `in1`=lfsr[2W-1:W], `in2`=lfsr[W-1:0].
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
  - IDLE: `start`=1 → load LFSR=`SEED` (0→1), idx=0, `err_count`=0, `fail_bits`=0, `done`=0 → DRIVE.
  - DRIVE (1 cycle): register `in1`/`in2` from the LFSR; `settle_cnt`=`SETTLE_CYCLES`-1 → SETTLE.
  - SETTLE: while `settle_cnt`≠0, decrement; when 0 → CHECK.
  - CHECK (1 cycle):
    - mism = `out1` ^ ~(`in1` & `in2`).
    - If mism≠0: `err_count`++ (saturating at max); `fail_bits` updated.
    - If idx==`NUM_VECTORS`-1 → DONE; else advance LFSR one step, idx++ → DRIVE.
  - DONE: `done`=1, `busy`=0, `in1`/`in2` held. `start` → same action as IDLE+start (restart).
- Timing:
  - Per-vector latency = `SETTLE_CYCLES`+2 cycles.
  - `start` sampled at edge T → `done` first high after edge T+`NUM_VECTORS`*(`SETTLE_CYCLES`+2). Defaults: 80 cycles.
- Boundaries:
  - `start` while `busy` is ignored.
  - `start` and `rst` in the same cycle: `rst` wins.
  - `NUM_VECTORS`=1: a single DRIVE/SETTLE/CHECK pass.
  - `out1` containing X/Z counts as a mismatch (`!==` compare).

Optional Feature:
- Macro `GATE_CHECK_STOP_ON_FAIL_EN`.
- Defined:
  - The first mismatching CHECK goes directly to DONE; `err_count`=1.
  - `fail_bits`=that vector's mism.
  - LFSR/idx are frozen, so the failing `in1`/`in2` remain visible.
- Undefined:
  - All `NUM_VECTORS` are applied.
  - `fail_bits` = sticky OR of every vector's mism.

Decomposition:
- Shared header (Verilog-2005 has no package):
  - state encodings (IDLE=0 … DONE=4);
  - LFSR tap masks per 2*`WIDTH` (8: 8'hB8, 16: 16'hB400, 32: 32'h80200003).
- Sub-module `gate_array_nand`: wraps the `#2` nand instance array, for bench pairing and for fault-injection variants. The checker itself instantiates none.

Test Plan:
1. Defaults + good `gate_array_nand`; `rst` 2 cycles; `start` pulse → after 80 cycles `done`=1, `pass`=1, `err_count`=0, `fail_bits`=0. The first DRIVE shows `in1`=8'hAC, `in2`=8'hE1, and the expected `out1`=8'h5F.
2. Bank with bit 3 stuck-0 (`out1`[3] forced 0) → `err_count` = number of the 16 vectors whose expected bit 3=1; `fail_bits`=8'h08; `pass`=0.
3. Mid-run `rst` at cycle 20 after `start` → next cycle `busy`=0, `done`=0, `in1`=`in2`=0, `err_count`=0; a new `start` yields the full result from test 1.
4. `start` re-pulsed while `busy` (cycle 10) → ignored; `done` still at cycle 80. Simultaneous `start`+`rst` → stays IDLE.
5. `SEED`=0, `NUM_VECTORS`=1, `SETTLE_CYCLES`=1 → LFSR loads 16'h0001; `in1`=8'h00, `in2`=8'h01; `done` after 3 cycles; `pass`=1.
6. With `GATE_CHECK_STOP_ON_FAIL_EN` defined and the stuck-0 bank of test 2 → DONE right after the first failing CHECK; `err_count`=1; `fail_bits`=8'h08; `in1`/`in2` hold the failing vector.

Source files
------------

// File: rtl/gate_array_checker_pkg.sv
// Shared definitions for the gate-array checker: FSM state encodings and
// Galois LFSR tap masks keyed by LFSR width (2*WIDTH).
package gate_array_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Right-shifting Galois tap masks; unknown widths fall back to the 16-bit mask.
  function automatic logic [63:0] lfsr_taps(input int n);
    case (n)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_B400;
      32:      return 64'h0000_0000_8020_0003;
      default: return 64'h0000_0000_0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/gate_array_checker_nand.sv
// gate_array_nand: the NAND gate bank the checker is paired with, one
// primitive per lane. Kept separate so fault variants can replace it.
module gate_array_nand #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out1
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nand u_nand (out1[i], in1[i], in2[i]);
  end

endmodule

// File: rtl/gate_array_checker.sv
// gate_array_checker: drives LFSR vectors into a NAND bank, waits a settle
// window, and compares the bank response with ~(in1 & in2).
// Optional: define GATE_CHECK_STOP_ON_FAIL_EN to stop at the first mismatch,
// freezing the failing vector on in1/in2.
module gate_array_checker
  import gate_array_checker_pkg::*;
#(
  parameter int                 WIDTH         = 8,
  parameter int                 NUM_VECTORS   = 16,
  parameter int                 SETTLE_CYCLES = 3,
  parameter logic [2*WIDTH-1:0] SEED          = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic [WIDTH-1:0]                 in1,
  output logic [WIDTH-1:0]                 in2,
  input  logic [WIDTH-1:0]                 out1,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [$clog2(NUM_VECTORS+1)-1:0] err_count,
  output logic [WIDTH-1:0]                 fail_bits
);

  localparam int LW = 2 * WIDTH;
  localparam int CW = $clog2(NUM_VECTORS + 1);
  localparam int IW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [LW-1:0] TAPS      = LW'(lfsr_taps(LW));
  localparam logic [LW-1:0] SEED_INIT = (SEED == '0) ? LW'(1) : SEED;

  state_t           state;
  logic [LW-1:0]    lfsr;
  logic [LW-1:0]    lfsr_step;
  logic [IW-1:0]    idx;
  logic [SW-1:0]    settle_cnt;
  logic [WIDTH-1:0] expect_v;
  logic [WIDTH-1:0] mism;
  logic             any_mism;
  logic             last_vec;
  logic             stop;

  // Next LFSR value, per-bit mismatch (X/Z on out1 counts as a miss) and end-of-run decision.
  always_comb begin
    lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    expect_v  = ~(in1 & in2);
    mism      = '0;
    for (int i = 0; i < WIDTH; i++) mism[i] = (out1[i] !== expect_v[i]);
    any_mism  = |mism;
    last_vec  = (idx == IW'(NUM_VECTORS - 1));
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    stop      = last_vec | any_mism;
`else
    stop      = last_vec;
`endif
  end

  // Run sequencer: vector generation, settle wait, compare and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      in1        <= '0;
      in2        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_bits  <= '0;
      lfsr       <= SEED_INIT;
      idx        <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // A start from DONE restarts exactly like one from IDLE.
          if (start) begin
            lfsr      <= SEED_INIT;
            idx       <= '0;
            err_count <= '0;
            fail_bits <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          in1        <= lfsr[LW-1:WIDTH];
          in2        <= lfsr[WIDTH-1:0];
          settle_cnt <= SW'(SETTLE_CYCLES - 1);
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) state <= ST_CHECK;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        ST_CHECK: begin
          if (any_mism && err_count != {CW{1'b1}}) err_count <= err_count + 1'b1;
          fail_bits <= fail_bits | mism;
          if (stop) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_count == '0) && !any_mism;
          end else begin
            lfsr  <= lfsr_step;
            idx   <= idx + 1'b1;
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
